uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx.sv | 116 +++++++++++
 tb/tb_uart_rx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and receiver state encoding.
package uart_pkg;

    localparam int DBIT_DEF       = 8;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int SB_TICK_DEF    = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input, reset to a chosen level.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; both stages reset to the idle level of the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled via the external s_tick enable.
//
// state    | meaning
// ---------|-------------------------------------------------------------
// ST_IDLE  | line idle, waiting for a low level on rx_s
// ST_START | counting to mid start bit to confirm it is still low
// ST_DATA  | sampling data bits at mid-bit, LSB first
// ST_STOP  | waiting to mid stop bit, then report byte or framing error
// ST_BREAK | stop bit was low; wait for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT       = DBIT_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int SB_TICK    = SB_TICK_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] d_out,
    output logic            rx_done,
    output logic            frame_err
);

    localparam logic [3:0] S_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] S_BIT  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] S_STOP = 4'(SB_TICK - 1);
    localparam logic [2:0] N_LAST = 3'(DBIT - 1);

    rx_state_t       state;
    logic [3:0]      s;
    logic [2:0]      n;
    logic [DBIT-1:0] shreg;
    logic            rx_s;

    uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // Receive FSM; everything advances only on s_tick, so a stalled tick freezes the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            s         <= '0;
            n         <= '0;
            shreg     <= '0;
            d_out     <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            if (s_tick) begin
                case (state)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state <= ST_START;
                            s     <= '0;
                        end
                    end
                    ST_START: begin
                        if (s == S_MID) begin
                            if (!rx_s) begin
                                state <= ST_DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                    ST_DATA: begin
                        if (s == S_BIT) begin
                            s     <= '0;
                            shreg <= {rx_s, shreg[DBIT-1:1]};
                            if (n == N_LAST) begin
                                state <= ST_STOP;
                            end else begin
                                n <= n + 3'd1;
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                    ST_STOP: begin
                        if (s == S_STOP) begin
                            if (rx_s) begin
                                d_out   <= shreg;
                                rx_done <= 1'b1;
                                state   <= ST_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= ST_BREAK;
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                    ST_BREAK: begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames checked against an event-level reference model.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] d_out;
    logic       rx_done;
    logic       frame_err;

    uart_rx dut (
        .clk       (clk),
        .reset     (reset),
        .s_tick    (s_tick),
        .rx        (rx),
        .d_out     (d_out),
        .rx_done   (rx_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int tick_div = 4;
    int div_cnt  = 0;
    int cyc      = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Baud tick: one clk-wide pulse every tick_div clocks (tick_div=1 means stuck high).
    always @(negedge clk) begin
        s_tick  = (div_cnt == 0);
        div_cnt = (div_cnt + 1 >= tick_div) ? 0 : div_cnt + 1;
    end

    typedef struct {
        logic       done;
        logic       err;
        logic [7:0] data;
        int         at;
    } ev_t;

    ev_t obs[$];
    ev_t exp_q[$];

    // Record every output pulse cycle; a pulse lasting two clocks shows up twice.
    always @(negedge clk) begin
        if (rx_done || frame_err) obs.push_back('{rx_done, frame_err, d_out, cyc});
    end

    int         checks = 0;
    int         failures = 0;
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic wait_ticks(input int num);
        int seen = 0;
        while (seen < num) begin
            @(negedge clk);
            #1;
            if (s_tick) seen++;
        end
    endtask

    // Drive one frame bit-by-bit in units of 16 ticks; line is left at the stop level.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_ticks(16);
        end
        rx = stop;
        wait_ticks(16);
    endtask

    task automatic expect_good(input logic [7:0] d);
        exp_q.push_back('{1'b1, 1'b0, d, 0});
        last_good = d;
    endtask

    task automatic expect_err();
        exp_q.push_back('{1'b0, 1'b1, last_good, 0});
    endtask

    task automatic compare_events(input string tag);
        int m;
        chk($sformatf("%s_count", tag), 32'(obs.size()), 32'(exp_q.size()));
        m = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_kind%0d", tag, i), {30'd0, obs[i].done, obs[i].err},
                {30'd0, exp_q[i].done, exp_q[i].err});
            chk($sformatf("%s_data%0d", tag, i), {24'd0, obs[i].data}, {24'd0, exp_q[i].data});
        end
        obs.delete();
        exp_q.delete();
    endtask

    initial begin
        int         t0;
        int         lat;
        logic [7:0] d;
        logic       stop;
        int         divs[4];
        divs[0] = 1; divs[1] = 2; divs[2] = 3; divs[3] = 5;

        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("rst_d_out", {24'd0, d_out}, 32'h0);
        chk("rst_rx_done", {31'd0, rx_done}, 32'h0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'h0);
        reset = 1'b0;

        repeat (1000) @(negedge clk);
        #1;
        chk("idle_d_out", {24'd0, d_out}, 32'h0);
        compare_events("idle");

        wait_ticks(1);
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        expect_good(8'hA5);
        wait_ticks(4);
        lat = (obs.size() > 0) ? obs[0].at - t0 : -1;
        chk("a5_latency_in_window", {31'd0, (lat >= 590 && lat <= 640)}, 32'h1);
        compare_events("a5");

        send_frame(8'h00, 1'b1); expect_good(8'h00);
        send_frame(8'hFF, 1'b1); expect_good(8'hFF);
        send_frame(8'h3C, 1'b1); expect_good(8'h3C);
        wait_ticks(4);
        compare_events("b2b");

        send_frame(8'h5A, 1'b1); expect_good(8'h5A);
        send_frame(8'h77, 1'b0); expect_err();
        wait_ticks(40);
        compare_events("ferr");
        chk("ferr_d_out_hold", {24'd0, d_out}, 32'h5A);
        rx = 1'b1;
        wait_ticks(20);
        compare_events("ferr_release");
        send_frame(8'h11, 1'b1); expect_good(8'h11);
        wait_ticks(4);
        compare_events("after_break");

        rx = 1'b0;
        wait_ticks(5);
        rx = 1'b1;
        wait_ticks(20);
        compare_events("glitch");
        send_frame(8'hC3, 1'b1); expect_good(8'hC3);
        wait_ticks(4);
        compare_events("after_glitch");

        rx = 1'b0;
        wait_ticks(16);
        d = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            wait_ticks(16);
        end
        rx = d[4];
        wait_ticks(8);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("midrst_d_out", {24'd0, d_out}, 32'h0);
        chk("midrst_rx_done", {31'd0, rx_done}, 32'h0);
        chk("midrst_frame_err", {31'd0, frame_err}, 32'h0);
        reset = 1'b0;
        last_good = 8'h00;
        wait_ticks(20);
        compare_events("midrst_discard");
        send_frame(8'h81, 1'b1); expect_good(8'h81);
        wait_ticks(4);
        compare_events("after_midrst");

        for (int f = 0; f < 16; f++) begin
            if (f % 4 == 0) tick_div = divs[f / 4];
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, stop);
            if (stop) begin
                expect_good(d);
                wait_ticks($urandom_range(0, 3));
            end else begin
                expect_err();
                rx = 1'b1;
                wait_ticks($urandom_range(3, 6));
            end
        end
        rx = 1'b1;
        wait_ticks(4);
        compare_events("random");
        chk("random_d_out_last_good", {24'd0, d_out}, {24'd0, last_good});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
